// File: rtl/ide_pingpong_buffer.sv
// Multi-bank IDE transmit buffer: byte-wide fill side, 16-bit drain side, DMARQ sequencer.
// Optional drained-word statistics counter enabled by IDE_PINGPONG_STATS_EN.
module ide_pingpong_buffer #(
   parameter int DEPTH_LOG2 = 8,
   parameter int NBANK_LOG2 = 1
) (
   input  logic                          clk,
   input  logic                          rst_,
   input  logic                          cfg_start,
   input  logic [7:0]                    cfg_count,
   input  logic [DEPTH_LOG2-1:0]         cfg_last_word,
   input  logic                          abort,
   input  logic                          fill_we,
   input  logic [DEPTH_LOG2:0]           fill_addr,
   input  logic [7:0]                    fill_data,
   input  logic                          fill_done,
   input  logic                          drain_strobe,
   output logic [15:0]                   drain_data,
   output logic                          dmarq,
   output logic                          busy,
   output logic                          done,
   output logic [(1<<NBANK_LOG2)-1:0]    bank_full,
   output logic                          overrun,
   output logic                          underrun,
   output logic [15:0]                   words_xfered
);
   localparam int NBANK = 1 << NBANK_LOG2;
   localparam int AW    = DEPTH_LOG2 + NBANK_LOG2;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_XFER, ST_DONE} state_t;

   state_t                state, state_n;
   logic [NBANK_LOG2-1:0] fill_bank, fill_bank_n, drain_bank, drain_bank_n;
   logic [DEPTH_LOG2-1:0] drain_pos, drain_pos_n, last, last_n;
   logic [7:0]            remaining, remaining_n;
   logic [NBANK-1:0]      full, full_n;
   logic                  overrun_n, underrun_n;
   logic                  stat_clr, stat_inc;
   logic [15:0]           mem [0:(1<<AW)-1];
   logic [15:0]           rd_q;
   logic [AW-1:0]         waddr, raddr;

   assign waddr = {fill_bank, fill_addr[DEPTH_LOG2:1]};
   assign raddr = {drain_bank, drain_pos};

   always_comb begin
      state_n      = state;
      full_n       = full;
      fill_bank_n  = fill_bank;
      drain_bank_n = drain_bank;
      drain_pos_n  = drain_pos;
      remaining_n  = remaining;
      last_n       = last;
      overrun_n    = overrun;
      underrun_n   = underrun;
      stat_clr     = 1'b0;
      stat_inc     = 1'b0;
      if (abort) begin
         state_n = ST_IDLE;
         full_n  = '0;
      end else begin
         case (state)
            ST_IDLE: if (cfg_start) begin
               full_n       = '0;
               fill_bank_n  = '0;
               drain_bank_n = '0;
               drain_pos_n  = '0;
               overrun_n    = 1'b0;
               underrun_n   = 1'b0;
               stat_clr     = 1'b1;
               last_n       = cfg_last_word;
               if (cfg_count == 8'd0) begin
                  state_n = ST_DONE;
               end else begin
                  remaining_n = cfg_count;
                  state_n     = ST_WAIT;
               end
            end
            ST_WAIT: if (full[drain_bank]) state_n = ST_XFER;
            ST_XFER: if (drain_strobe) begin
               stat_inc = 1'b1;
               if (drain_pos != last) begin
                  drain_pos_n = drain_pos + 1'b1;
               end else begin
                  full_n[drain_bank] = 1'b0;
                  drain_bank_n       = drain_bank + 1'b1;
                  drain_pos_n        = '0;
                  remaining_n        = remaining - 8'd1;
                  state_n            = (remaining == 8'd1) ? ST_DONE : ST_WAIT;
               end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
         endcase
         if (drain_strobe && state != ST_XFER) underrun_n = 1'b1;
         // Fill acceptance looks at full_n so a same-cycle drain-complete clear lands first.
         if (fill_done && (state == ST_WAIT || state == ST_XFER)) begin
            if (!full_n[fill_bank]) begin
               full_n[fill_bank] = 1'b1;
               fill_bank_n       = fill_bank + 1'b1;
            end else begin
               overrun_n = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state      <= ST_IDLE;
         full       <= '0;
         fill_bank  <= '0;
         drain_bank <= '0;
         drain_pos  <= '0;
         remaining  <= '0;
         last       <= '0;
         overrun    <= 1'b0;
         underrun   <= 1'b0;
         dmarq      <= 1'b0;
         drain_data <= '0;
      end else begin
         state      <= state_n;
         full       <= full_n;
         fill_bank  <= fill_bank_n;
         drain_bank <= drain_bank_n;
         drain_pos  <= drain_pos_n;
         remaining  <= remaining_n;
         last       <= last_n;
         overrun    <= overrun_n;
         underrun   <= underrun_n;
         dmarq      <= (state_n == ST_XFER);
         drain_data <= rd_q;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_we && state != ST_IDLE && !abort) begin
         if (fill_addr[0]) mem[waddr][15:8] <= fill_data;
         else              mem[waddr][7:0]  <= fill_data;
      end
      rd_q <= mem[raddr];
   end

   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);
   assign bank_full = full;

`ifdef IDE_PINGPONG_STATS_EN
   logic [15:0] words_q;
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_)         words_q <= '0;
      else if (stat_clr) words_q <= '0;
      else if (stat_inc) words_q <= words_q + 16'd1;
   end
   assign words_xfered = words_q;
`else
   logic unused_stats;
   assign unused_stats = stat_clr ^ stat_inc;
   assign words_xfered = '0;
`endif

endmodule

// File: tb/tb_ide_pingpong_buffer.sv
// Directed self-checking bench for ide_pingpong_buffer (default 2 banks x 256 words).
module tb_ide_pingpong_buffer;
   logic        clk = 1'b0;
   logic        rst_;
   logic        cfg_start, abort, fill_we, fill_done, drain_strobe;
   logic [7:0]  cfg_count, fill_data;
   logic [7:0]  cfg_last_word;
   logic [8:0]  fill_addr;
   logic [15:0] drain_data, words_xfered;
   logic        dmarq, busy, done, overrun, underrun;
   logic [1:0]  bank_full;
   int          checks = 0;
   int          passed = 0;
`ifdef IDE_PINGPONG_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   ide_pingpong_buffer #(.DEPTH_LOG2(8), .NBANK_LOG2(1)) dut (
      .clk(clk), .rst_(rst_), .cfg_start(cfg_start), .cfg_count(cfg_count),
      .cfg_last_word(cfg_last_word), .abort(abort), .fill_we(fill_we),
      .fill_addr(fill_addr), .fill_data(fill_data), .fill_done(fill_done),
      .drain_strobe(drain_strobe), .drain_data(drain_data), .dmarq(dmarq),
      .busy(busy), .done(done), .bank_full(bank_full), .overrun(overrun),
      .underrun(underrun), .words_xfered(words_xfered)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] byte_of(input int seed, input int i);
      logic [31:0] t;
      t = i + seed * 37;
      return t[7:0];
   endfunction

   function automatic logic [15:0] word_of(input int seed, input int w);
      return {byte_of(seed, 2*w+1), byte_of(seed, 2*w)};
   endfunction

   task automatic pulse_start(input logic [7:0] cnt, input logic [7:0] lst);
      cfg_start = 1'b1; cfg_count = cnt; cfg_last_word = lst;
      @(negedge clk);
      cfg_start = 1'b0;
   endtask

   task automatic fill(input int seed, input int nbytes);
      for (int i = 0; i < nbytes; i++) begin
         fill_we = 1'b1; fill_addr = 9'(i); fill_data = byte_of(seed, i);
         @(negedge clk);
      end
      fill_we = 1'b0;
   endtask

   task automatic pulse_fill_done;
      fill_done = 1'b1;
      @(negedge clk);
      fill_done = 1'b0;
   endtask

   task automatic strobe_gap;
      drain_strobe = 1'b1;
      @(negedge clk);
      drain_strobe = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic wait_dmarq(input string name);
      int n = 0;
      while (dmarq !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
      checks++;
      if (dmarq !== 1'b1) $display("FAIL %s_dmarq_rise got=%b want=1", name, dmarq);
      else passed++;
      @(negedge clk);
      @(negedge clk);
   endtask

   // Drains one full 256-word bank, checking data, DMARQ fall/regap and done.
   task automatic drain_bank(input int seed, input bit final_bank, input bit expect_gap, input string name);
      bit bad = 1'b0;
      int bw = 0;
      logic [15:0] bgot = '0, bexp = '0;
      wait_dmarq(name);
      for (int w = 0; w < 256; w++) begin
         if (!bad && drain_data !== word_of(seed, w)) begin
            bad = 1'b1; bw = w; bgot = drain_data; bexp = word_of(seed, w);
         end
         drain_strobe = 1'b1;
         @(negedge clk);
         drain_strobe = 1'b0;
         if (w == 255) begin
            checks++;
            if (dmarq !== 1'b0) $display("FAIL %s_dmarq_fall got=%b want=0", name, dmarq);
            else passed++;
            checks++;
            if (done !== final_bank) $display("FAIL %s_done got=%b want=%b", name, done, final_bank);
            else passed++;
            if (expect_gap) begin
               @(negedge clk);
               checks++;
               if (dmarq !== 1'b1) $display("FAIL %s_dmarq_regap got=%b want=1", name, dmarq);
               else passed++;
            end
         end else begin
            @(negedge clk);
            @(negedge clk);
         end
      end
      checks++;
      if (bad) $display("FAIL %s_data word=%0d got=%h want=%h", name, bw, bgot, bexp);
      else passed++;
   endtask

   task automatic test_reset;
      rst_ = 1'b0;
      cfg_start = 0; cfg_count = 0; cfg_last_word = 0; abort = 0;
      fill_we = 0; fill_addr = 0; fill_data = 0; fill_done = 0; drain_strobe = 0;
      repeat (2) @(negedge clk);
      checks++;
      if ({dmarq, busy, done, bank_full, overrun, underrun, words_xfered, drain_data} !== '0)
         $display("FAIL reset_outputs got=%b%b%b %b %b%b %h %h want=all zero",
                  dmarq, busy, done, bank_full, overrun, underrun, words_xfered, drain_data);
      else passed++;
      rst_ = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_sector;
      pulse_start(8'd1, 8'd255);
      fill(0, 512);
      pulse_fill_done;
      drain_bank(0, 1'b1, 1'b0, "single");
      @(negedge clk);
      checks++;
      if ({done, busy} !== 2'b00) $display("FAIL single_idle got done=%b busy=%b want=0 0", done, busy);
      else passed++;
      checks++;
      if (bank_full !== 2'b00) $display("FAIL single_bank_full got=%b want=00", bank_full);
      else passed++;
      checks++;
      if (words_xfered !== (STATS ? 16'd256 : 16'd0))
         $display("FAIL single_words got=%0d want=%0d", words_xfered, STATS ? 256 : 0);
      else passed++;
   endtask

   task automatic test_pingpong;
      pulse_start(8'd3, 8'd255);
      fill(0, 512);
      pulse_fill_done;
      fork
         begin
            fill(1, 512);
            pulse_fill_done;
            for (int n = 0; n < 4000 && bank_full[0] !== 1'b0; n++) @(negedge clk);
            fill(2, 512);
            pulse_fill_done;
         end
         begin
            drain_bank(0, 1'b0, 1'b1, "pp_bank0");
            drain_bank(1, 1'b0, 1'b1, "pp_bank1");
            drain_bank(2, 1'b1, 1'b0, "pp_bank2");
         end
      join
      @(negedge clk);
      checks++;
      if ({overrun, underrun, busy} !== 3'b000)
         $display("FAIL pp_flags got ovr=%b und=%b busy=%b want=0 0 0", overrun, underrun, busy);
      else passed++;
      checks++;
      if (words_xfered !== (STATS ? 16'd768 : 16'd0))
         $display("FAIL pp_words got=%0d want=%0d", words_xfered, STATS ? 768 : 0);
      else passed++;
   endtask

   task automatic test_overrun;
      pulse_start(8'd4, 8'd255);
      pulse_fill_done;
      pulse_fill_done;
      checks++;
      if ({bank_full, overrun} !== 3'b110) $display("FAIL ovr_two got full=%b ovr=%b want=11 0", bank_full, overrun);
      else passed++;
      pulse_fill_done;
      checks++;
      if ({bank_full, overrun, dmarq} !== 4'b1111)
         $display("FAIL ovr_third got full=%b ovr=%b dmarq=%b want=11 1 1", bank_full, overrun, dmarq);
      else passed++;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if ({bank_full, dmarq, busy, overrun} !== 5'b00001)
         $display("FAIL ovr_abort got full=%b dmarq=%b busy=%b ovr=%b want=00 0 0 1", bank_full, dmarq, busy, overrun);
      else passed++;
   endtask

   task automatic test_underrun_simul;
      pulse_start(8'd2, 8'd3);
      drain_strobe = 1'b1;
      @(negedge clk);
      drain_strobe = 1'b0;
      checks++;
      if (underrun !== 1'b1) $display("FAIL und_wait got=%b want=1", underrun);
      else passed++;
      fill(0, 8);
      pulse_fill_done;
      pulse_fill_done;
      wait_dmarq("und");
      for (int w = 0; w < 3; w++) strobe_gap();
      checks++;
      if (drain_data !== 16'h0706) $display("FAIL und_word3 got=%h want=0706", drain_data);
      else passed++;
      drain_strobe = 1'b1; fill_done = 1'b1;
      @(negedge clk);
      drain_strobe = 1'b0; fill_done = 1'b0;
      checks++;
      if ({bank_full, overrun, underrun, dmarq} !== 5'b11010)
         $display("FAIL und_simul got full=%b ovr=%b und=%b dmarq=%b want=11 0 1 0",
                  bank_full, overrun, underrun, dmarq);
      else passed++;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   task automatic test_abort;
      bit saw_done = 1'b0;
      pulse_start(8'd2, 8'd255);
      fill(0, 512);
      pulse_fill_done;
      wait_dmarq("abort");
      for (int w = 0; w < 100; w++) strobe_gap();
      checks++;
      if (drain_data !== 16'hC9C8) $display("FAIL abort_word100 got=%h want=c9c8", drain_data);
      else passed++;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if ({busy, dmarq, bank_full, overrun, underrun} !== 6'b0)
         $display("FAIL abort_state got busy=%b dmarq=%b full=%b ovr=%b und=%b want=all 0",
                  busy, dmarq, bank_full, overrun, underrun);
      else passed++;
      for (int i = 0; i < 6; i++) begin
         if (done) saw_done = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (saw_done !== 1'b0) $display("FAIL abort_no_done got=%b want=0", saw_done);
      else passed++;
   endtask

   task automatic test_reset_mid;
      pulse_start(8'd1, 8'd255);
      drain_strobe = 1'b1;
      @(negedge clk);
      drain_strobe = 1'b0;
      fill(0, 16);
      pulse_fill_done;
      wait_dmarq("rst");
      for (int w = 0; w < 3; w++) strobe_gap();
      checks++;
      if ({dmarq, underrun, drain_data} !== {2'b11, 16'h0706})
         $display("FAIL rst_pre got dmarq=%b und=%b data=%h want=1 1 0706", dmarq, underrun, drain_data);
      else passed++;
      #2 rst_ = 1'b0;
      #1;
      checks++;
      if ({dmarq, busy, done, bank_full, overrun, underrun, words_xfered, drain_data} !== '0)
         $display("FAIL rst_async got=%b%b%b %b %b%b %h %h want=all zero",
                  dmarq, busy, done, bank_full, overrun, underrun, words_xfered, drain_data);
      else passed++;
      @(negedge clk);
      @(negedge clk);
      rst_ = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_count_zero;
      int ndone = 0;
      bit saw_dmarq = 1'b0;
      pulse_start(8'd0, 8'd255);
      for (int i = 0; i < 4; i++) begin
         if (done) ndone++;
         if (dmarq) saw_dmarq = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (ndone != 1) $display("FAIL zero_done_pulses got=%0d want=1", ndone);
      else passed++;
      checks++;
      if ({saw_dmarq, busy} !== 2'b00) $display("FAIL zero_dmarq_busy got=%b%b want=00", saw_dmarq, busy);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_single_sector();
      test_pingpong();
      test_overrun();
      test_underrun_simul();
      test_abort();
      test_reset_mid();
      test_count_zero();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
